// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller state encodings and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one
// iteration per clock. Signed operations run on magnitudes and are
// sign-corrected in a final FIX cycle. MTHI/MTLO write HI/LO while idle.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | WIDTH iterations on the working register
// S_FIX  | sign correction, HI/LO update, done pulse next cycle
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   start, op        launch request and operation (MULT/MULTU/DIV/DIVU)
//   rs_data, rt_data operand A / dividend, operand B / divisor
//   hi_we, lo_we     MTHI / MTLO write enables, data on wdata
//   busy, done       operation in progress / one-cycle completion pulse
//   hi, lo           architectural HI and LO registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               is_div, neg_res, neg_rem;

  // Operand decode at launch
  logic             op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & rs_data[WIDTH-1];
  assign b_neg     = op_signed & rt_data[WIDTH-1];
  assign a_mag_in  = a_neg ? -rs_data : rs_data;
  assign b_mag_in  = b_neg ? -rt_data : rt_data;

  // Shared WIDTH+1-bit adder: adds the multiplicand for multiply, subtracts
  // the divisor (invert plus carry-in) for divide.
  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               add_cin;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    add_a    = {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b    = '0;
    add_cin  = 1'b0;
    acc_step = acc;
    if (is_div) begin
      // Partial remainder shifted left with the next dividend bit.
      add_a   = acc[2*WIDTH-1:WIDTH-1];
      add_b   = ~{1'b0, b_mag};
      add_cin = 1'b1;
    end else if (acc[0]) begin
      add_b = {1'b0, a_mag};
    end
    add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
    if (is_div) begin
      // Top bit of the difference is the borrow: restore on negative.
      if (!add_sum[WIDTH])
        acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {add_a[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {add_sum, acc[WIDTH-1:1]};
    end
  end

  // Final result selection with sign correction
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_mag == '0) begin
      // Divide by zero: quotient all ones, HI returns the original dividend.
      res_hi = neg_rem ? -a_mag : a_mag;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= CW'(WIDTH-1);
            a_mag   <= a_mag_in;
            b_mag   <= b_mag_in;
            is_div  <= op_div;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of it.
            acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag_in : b_mag_in)};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit dut (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clock = ~clock;

  // Reference model built from native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a negedge; drives start immediately so consecutive calls run
  // back-to-back (start in the done cycle).
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input bit poke_start, input bit poke_calc);
    logic [31:0] pre_hi, pre_lo;
    int busy_n;
    bit held, got;
    logic [63:0] want;
    pre_hi  = hi;
    pre_lo  = lo;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    hi_we   = poke_start;
    lo_we   = poke_start;
    wdata   = 32'hDEAD_BEEF;
    sb_q.push_back(exp);
    busy_n = 0;
    held   = 1'b1;
    got    = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      start   = 1'b0;
      rs_data = $urandom;
      rt_data = $urandom;
      hi_we   = poke_calc && (c == 5);
      lo_we   = poke_calc && (c == 5);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
    end
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
    check({name, "_hilo_held"}, {63'h0, held}, 64'h1);
    want = sb_q.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_60", name);
    end else begin
      check({name, "_result"}, {hi, lo}, want);
      check({name, "_busy_at_done"}, {63'h0, busy}, 64'h0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    wdata   = '0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;

    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFF8, 32'd20,        64'hFFFF_FFFF_FFFF_FF60});
    vecs.push_back('{2'b10, 32'hFFFF_FFEC, 32'd8,         64'hFFFF_FFFC_FFFF_FFFE});
    vecs.push_back('{2'b11, 32'd20,        32'd8,         64'h0000_0004_0000_0002});
    vecs.push_back('{2'b11, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF});
    vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD});
    vecs.push_back('{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.op  = 2'(i % 4);
      v.a   = $urandom;
      v.b   = (i == 5) ? 32'(($urandom % 100) + 1) : $urandom;
      v.exp = model(v.op, v.a, v.b);
      vecs.push_back(v);
    end

    #12;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // MTHI, then MTHI+MTLO together
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'h0000_1234, 32'h0});
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_0055;
    @(negedge clock);
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hA5A5_0055, 32'hA5A5_0055});

    // Table vectors, back-to-back; first two also poke hi_we/lo_we at start
    // and during CALC, which must not disturb HI/LO.
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             (i == 0), (i == 1));

    @(negedge clock);
    check("done_one_cycle", {63'h0, done}, 64'h0);

    // Abort by reset in the middle of an operation
    start   = 1'b1;
    op      = 2'b01;
    rs_data = 32'd1234;
    rt_data = 32'd5678;
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("pre_abort_busy", {63'h0, busy}, 64'h1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_abort_idle", {63'h0, busy}, 64'h0);
    run_op("after_abort", 2'b01, 32'd3, 32'd5, 64'd15, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
